// File: rtl/apb_regbank_if.sv
// apb_regbank_if: APB slave bus bundle for apb_regbank
interface apb_regbank_if;
  logic [6:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb, input prdata, pready, pslverr);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_regbank.sv
// apb_regbank: APB register bank with control/status words, edge-latched interrupts and wait states
module apb_regbank #(
  parameter int          N_CTRL   = 4,
  parameter int          N_STAT   = 4,
  parameter int          N_IRQ    = 8,
  parameter int          WAIT     = 1,
  parameter logic [31:0] CTRL_RST = 32'h0,
  parameter logic [31:0] ID_VAL   = 32'h00216948
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   enable,
  apb_regbank_if.slave           bus,
  input  logic [32*N_STAT-1:0]   status_in,
  output logic [32*N_CTRL-1:0]   control_out,
  input  logic [N_IRQ-1:0]       irq_src,
  output logic                   irq
);
  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;
  state_t                   r_state, w_state_nxt;
  logic [2:0]               r_cnt, w_cnt_nxt;
  logic [N_CTRL-1:0][31:0]  r_ctrl;
  logic [N_IRQ-1:0]         r_raw, r_mask, r_src_q;
  logic                     r_irq;
  logic                     w_done, w_err, w_wr;
  logic                     w_is_ctrl, w_is_stat, w_is_raw, w_is_mask, w_is_pend, w_is_id;
  logic [2:0]               w_idx;
  logic [7:0][31:0]         w_stat, w_ctrl;
  logic [31:0]              w_bmask, w_rdata;
  logic [N_IRQ-1:0]         w_clr, w_rise;

  genvar k;
  for (k = 0; k < 8; k++) begin : g_word
    if (k < N_STAT) begin : g_s
      assign w_stat[k] = status_in[32*k +: 32];
    end else begin : g_sz
      assign w_stat[k] = '0;
    end
    if (k < N_CTRL) begin : g_c
      assign w_ctrl[k] = r_ctrl[k];
    end else begin : g_cz
      assign w_ctrl[k] = '0;
    end
  end

  assign w_idx     = bus.paddr[4:2];
  assign w_is_ctrl = bus.paddr[6:5] == 2'b00 && int'(w_idx) < N_CTRL;
  assign w_is_stat = bus.paddr[6:5] == 2'b01 && int'(w_idx) < N_STAT;
  assign w_is_raw  = bus.paddr[6:2] == 5'h10;
  assign w_is_mask = bus.paddr[6:2] == 5'h11;
  assign w_is_pend = bus.paddr[6:2] == 5'h12;
  assign w_is_id   = bus.paddr[6:2] == 5'h13;
  assign w_err     = (bus.paddr[1:0] != 2'b00)
                   | ~(w_is_ctrl | w_is_stat | w_is_raw | w_is_mask | w_is_pend | w_is_id)
                   | (bus.pwrite & (w_is_stat | w_is_pend | w_is_id));
  assign w_rdata   = w_is_ctrl ? w_ctrl[w_idx] :
                     w_is_stat ? w_stat[w_idx] :
                     w_is_raw  ? 32'(r_raw) :
                     w_is_mask ? 32'(r_mask) :
                     w_is_pend ? 32'(r_raw & r_mask) :
                     w_is_id   ? ID_VAL : 32'h0;
  assign w_bmask   = {{8{bus.pstrb[3]}}, {8{bus.pstrb[2]}}, {8{bus.pstrb[1]}}, {8{bus.pstrb[0]}}};
  assign w_wr      = w_done & bus.pwrite & ~w_err;
  assign w_clr     = (w_wr & w_is_raw) ? N_IRQ'(bus.pwdata & w_bmask) : '0;
  assign w_rise    = irq_src & ~r_src_q;

  assign bus.pready  = w_done;
  assign bus.pslverr = w_done & w_err;
  assign bus.prdata  = (w_done & ~bus.pwrite & ~w_err) ? w_rdata : 32'h0;
  assign control_out = r_ctrl;
  assign irq         = r_irq;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (bus.psel && !bus.penable) begin
        w_state_nxt = WAITING;
        w_cnt_nxt   = 3'(WAIT);
      end
      WAITING: if (!bus.psel) w_state_nxt = IDLE;
      else if (bus.penable) begin
        if (r_cnt == 3'd0) begin
          w_done      = enable;
          w_state_nxt = DONE;
        end else w_cnt_nxt = r_cnt - 3'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end

  // a rising source edge outranks a same-cycle W1C clear
  always_ff @(posedge pclk or negedge reset_n)
    if (!reset_n) begin
      r_ctrl  <= {N_CTRL{CTRL_RST}};
      r_raw   <= '0;
      r_mask  <= '0;
      r_src_q <= '0;
      r_irq   <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < N_CTRL; i++)
        if (w_wr && w_is_ctrl && w_idx == 3'(i)) r_ctrl[i] <= (r_ctrl[i] & ~w_bmask) | (bus.pwdata & w_bmask);
      if (w_wr && w_is_mask) r_mask <= (r_mask & ~N_IRQ'(w_bmask)) | N_IRQ'(bus.pwdata & w_bmask);
      r_raw   <= (r_raw & ~w_clr) | w_rise;
      r_src_q <= irq_src;
      r_irq   <= |(r_raw & r_mask);
    end
endmodule

// File: tb/tb_apb_regbank.sv
// tb_apb_regbank: directed self-checking bench for apb_regbank (WAIT=2)
module tb_apb_regbank;
  logic         pclk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b1;
  logic [127:0] status_in = {32'h44444444, 32'hCAFEF00D, 32'h22222222, 32'h11111111};
  logic [127:0] control_out;
  logic [7:0]   irq_src = 8'h0;
  logic         irq;
  int           n_chk = 0;
  int           n_err = 0;
  logic [31:0]  rd;
  logic         er;
  int           wt;

  apb_regbank_if bus();

  apb_regbank #(.WAIT(2)) dut (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .bus(bus.slave),
    .status_in(status_in), .control_out(control_out), .irq_src(irq_src), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic apb(input logic [6:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     input int stall, input bit edge3,
                     output logic [31:0] rdata, output logic err, output int waits);
    logic nz;
    bit   got;
    nz = 1'b0; got = 1'b0; waits = 0; rdata = '0; err = 1'b0;
    @(posedge pclk); #1;
    bus.paddr = a; bus.pwrite = w; bus.pwdata = d; bus.pstrb = s; bus.psel = 1'b1; bus.penable = 1'b0;
    @(negedge pclk);
    nz = bus.pready | (|bus.prdata) | bus.pslverr;
    @(posedge pclk); #1 bus.penable = 1'b1;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge pclk);
      if (bus.pready) begin
        got = 1'b1; rdata = bus.prdata; err = bus.pslverr;
        if (edge3) irq_src[3] = 1'b1;
      end else begin
        nz |= (|bus.prdata) | bus.pslverr;
        waits++;
        if (waits == stall) begin
          @(posedge pclk); #1 enable = 1'b0;
          repeat (5) begin
            @(negedge pclk);
            check("stall_pready", 32'(bus.pready), 0);
          end
          @(posedge pclk); #1 enable = 1'b1;
        end
      end
    end
    check("completed", 32'(got), 1);
    check("quiet_before_ready", 32'(nz), 0);
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    if (edge3) irq_src[3] = 1'b0;
    @(negedge pclk);
    check("single_ready", 32'(bus.pready), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0; bus.pwdata = '0; bus.pstrb = '0;
    #2;
    check("rst_pready", 32'(bus.pready), 0);
    check("rst_pslverr", 32'(bus.pslverr), 0);
    check("rst_prdata", bus.prdata, 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_ctrl0", control_out[31:0], 0);
    check("rst_ctrl3", control_out[127:96], 0);
    #20 reset_n = 1'b1;

    apb(7'h04, 1, 32'hA5A5A5A5, 4'b0101, 0, 0, rd, er, wt);
    check("wr_ctrl1_waits", wt, 2);
    check("wr_ctrl1_err", 32'(er), 0);
    check("ctrl1_val", control_out[63:32], 32'h00A500A5);
    apb(7'h04, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_ctrl1", rd, 32'h00A500A5);
    check("rd_ctrl1_waits", wt, 2);
    apb(7'h4C, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_id", rd, 32'h00216948);
    check("rd_id_err", 32'(er), 0);
    apb(7'h50, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_unmapped_err", 32'(er), 1);
    check("rd_unmapped_data", rd, 0);
    apb(7'h28, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_stat2", rd, 32'hCAFEF00D);

    apb(7'h20, 1, 32'h12345678, 4'hF, 0, 0, rd, er, wt);
    check("wr_stat_err", 32'(er), 1);
    apb(7'h20, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_stat0", rd, 32'h11111111);
    apb(7'h02, 1, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, wt);
    check("wr_misalign_err", 32'(er), 1);
    check("misalign_ctrl0", control_out[31:0], 0);
    check("misalign_ctrl1", control_out[63:32], 32'h00A500A5);
    apb(7'h4C, 1, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, wt);
    check("wr_id_err", 32'(er), 1);
    apb(7'h48, 1, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, wt);
    check("wr_pend_err", 32'(er), 1);

    apb(7'h00, 1, 32'h11223344, 4'hF, 0, 0, rd, er, wt);
    check("ctrl0_full", control_out[31:0], 32'h11223344);
    apb(7'h00, 1, 32'hAABBCCDD, 4'b1000, 0, 0, rd, er, wt);
    check("ctrl0_strb", control_out[31:0], 32'hAA223344);
    apb(7'h10, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_ctrl4_err", 32'(er), 1);
    apb(7'h30, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_stat4_err", 32'(er), 1);
    apb(7'h05, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_misalign_err", 32'(er), 1);
    check("rd_misalign_data", rd, 0);

    apb(7'h44, 1, 32'h00000008, 4'hF, 0, 0, rd, er, wt);
    apb(7'h44, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_mask", rd, 32'h08);
    @(posedge pclk); #1 irq_src[3] = 1'b1;
    @(negedge pclk);
    check("irq_before_edge", 32'(irq), 0);
    @(posedge pclk); #1 irq_src[3] = 1'b0;
    @(negedge pclk);
    check("irq_lag", 32'(irq), 0);
    @(negedge pclk);
    check("irq_set", 32'(irq), 1);
    apb(7'h40, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_raw", rd, 32'h08);
    apb(7'h48, 0, 0, 0, 0, 0, rd, er, wt);
    check("rd_pend", rd, 32'h08);
    apb(7'h40, 1, 32'h00000008, 4'hF, 0, 1, rd, er, wt);
    check("w1c_edge_err", 32'(er), 0);
    apb(7'h40, 0, 0, 0, 0, 0, rd, er, wt);
    check("raw_set_wins", rd, 32'h08);
    apb(7'h40, 1, 32'h00000008, 4'b1110, 0, 0, rd, er, wt);
    apb(7'h40, 0, 0, 0, 0, 0, rd, er, wt);
    check("raw_strb_kept", rd, 32'h08);
    check("irq_still", 32'(irq), 1);
    apb(7'h40, 1, 32'h00000008, 4'hF, 0, 0, rd, er, wt);
    check("irq_hold_after_clr", 32'(irq), 1);
    @(negedge pclk);
    check("irq_cleared", 32'(irq), 0);
    apb(7'h40, 0, 0, 0, 0, 0, rd, er, wt);
    check("raw_cleared", rd, 0);
    apb(7'h48, 0, 0, 0, 0, 0, rd, er, wt);
    check("pend_cleared", rd, 0);

    apb(7'h08, 1, 32'hDEADBEEF, 4'hF, 1, 0, rd, er, wt);
    check("stall_waits", wt, 2);
    check("stall_err", 32'(er), 0);
    check("stall_ctrl2", control_out[95:64], 32'hDEADBEEF);

    @(posedge pclk); #1;
    bus.paddr = 7'h04; bus.pwrite = 1'b1; bus.pwdata = 32'hFFFFFFFF; bus.pstrb = 4'hF; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge pclk); #1 bus.penable = 1'b1;
    @(negedge pclk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl1", control_out[63:32], 0);
    check("rst_mid_ctrl2", control_out[95:64], 0);
    check("rst_mid_pready", 32'(bus.pready), 0);
    @(posedge pclk); #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      check("no_setup_no_ready", 32'(bus.pready), 0);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    apb(7'h04, 0, 0, 0, 0, 0, rd, er, wt);
    check("post_rst_ctrl1", rd, 0);
    apb(7'h44, 0, 0, 0, 0, 0, rd, er, wt);
    check("post_rst_mask", rd, 0);
    check("post_rst_irq", 32'(irq), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/apb_regbank.md
APB_REGBANK -- requirements
Module: apb_regbank

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
 - N_CTRL, 4, number of RW control registers (1..8)
 - N_STAT, 4, number of RO status registers (1..8)
 - N_IRQ, 8, number of interrupt sources (1..32)
 - WAIT, 1, wait states per access (0..7)
 - CTRL_RST, 32'h0, reset value of every control register
 - ID_VAL, 32'h00216948, value read at ID
REQ-002 Ports SHALL be (name, direction, width, meaning):
 - pclk, in, 1, clock
 - reset_n, in, 1, reset (asynchronous, active-low)
 - enable, in, 1, clock-gating qualifier; all state frozen when 0
 - paddr, in, 7, byte address
 - psel / penable / pwrite, in, 1 each, APB control
 - pwdata, in, 32, write data
 - pstrb, in, 4, byte write strobes
 - prdata, out, 32, read data
 - pready, out, 1, transfer complete
 - pslverr, out, 1, transfer error
 - status_in, in, 32*N_STAT, status words, word i at [32i+31:32i]
 - control_out, out, 32*N_CTRL, control registers, same packing
 - irq_src, in, N_IRQ, interrupt sources
 - irq, out, 1, combined masked interrupt, registered

Function
REQ-003 Address map SHALL be (word-aligned):
 - 0x00+4i: CTRL[i], RW, i<N_CTRL
 - 0x20+4i: STAT[i], RO, i<N_STAT
 - 0x40: IRQ_RAW, read / write-1-to-clear
 - 0x44: IRQ_MASK, RW
 - 0x48: IRQ_PEND = RAW & MASK, RO
 - 0x4C: ID, RO
 - all else unmapped
REQ-004 FSM states SHALL be IDLE, WAITING, DONE. IDLE->WAITING on psel&~penable, loading cnt=WAIT. WAITING: cnt decrements each cycle while psel&penable; ->DONE when cnt==0 and penable. DONE->IDLE after one cycle.
REQ-005 pready SHALL be 1 only in DONE, or in WAITING with cnt==0 and penable; otherwise 0. With WAIT=0, access completes in the first penable cycle.
REQ-006 Write SHALL commit only on the completing cycle (psel&penable&pwrite&pready&~pslverr).
REQ-007 CTRL and IRQ_MASK writes SHALL update only bytes whose pstrb bit is 1.
REQ-008 IRQ_RAW writes SHALL clear bit b where pwdata[b]=1 and pstrb[b/8]=1.
REQ-009 prdata SHALL carry the addressed value, zero-extended to 32 bits (IRQ regs above N_IRQ read 0), when pready=1 and read; otherwise prdata SHALL be 32'h0, so buses can be ORed.
REQ-010 pslverr SHALL be 1 only together with pready=1 when any of these holds: unmapped address; paddr[1:0]!=0; write to STAT, IRQ_PEND or ID. Errored writes SHALL change no state; errored reads SHALL return 0.
REQ-011 psel deasserted in WAITING SHALL return the FSM to IDLE with no write and no pready.
REQ-012 IRQ_RAW[b] SHALL set on a rising edge of irq_src[b] (registered previous-value detector). If a set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-013 irq SHALL equal the registered |(IRQ_RAW & IRQ_MASK), one cycle after the contributing state.
REQ-014 When enable=0, the FSM, counter, registers, edge detector and irq SHALL hold their values, and pready SHALL be 0.
REQ-015 pready SHALL be 0 in IDLE; the block never inserts a response without a setup phase.

Reset
REQ-016 While reset_n=0, regardless of clock:
 - FSM=IDLE, cnt=0
 - every CTRL=CTRL_RST
 - IRQ_RAW=0, IRQ_MASK=0, edge detector=0
 - irq=0, prdata=0, pready=0, pslverr=0
REQ-017 Reset asserted mid-transfer SHALL abort the transfer with no write. After release, the first transfer requires a new setup phase.

Verification
REQ-018 WAIT=2: write 0xA5A5A5A5 to 0x04, pstrb=4'b0101 -> pready low for 2 penable cycles then high 1 cycle; CTRL[1]=0x00A500A5 (from 0), pslverr=0.
REQ-019 Read 0x4C -> prdata=ID_VAL exactly in the pready cycle, 0 otherwise; read 0x50 -> pslverr=1, prdata=0.
REQ-020 Write 0x12345678 to 0x20 -> pslverr=1, STAT unaffected; write to 0x02 -> pslverr=1, no register changes.
REQ-021 Pulse irq_src[3], MASK=0x08 -> RAW=0x08, irq=1 one cycle later. W1C 0x08 in the same cycle as a new irq_src[3] edge -> RAW stays 0x08. W1C without an edge -> RAW=0, irq=0 next cycle.
REQ-022 enable=0 during WAITING for 5 cycles -> pready held 0, cnt frozen; transfer completes normally after enable=1. reset_n pulse mid-write -> CTRL=CTRL_RST, no commit.
